// File: rtl/encoder_fec_ctrl.sv
// rtl/encoder_fec_ctrl.sv - frame sequencer: input buffer -> Hamming encoder -> output buffer
module encoder_fec_ctrl #(
  parameter int DATA_WIDTH     = 8,
  parameter int HAMMING_WIDTH  = 16,
  parameter int ENTRIES_BUFFER = 1024,
  parameter int CNT_WIDTH      = $clog2(ENTRIES_BUFFER) + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     abort,
  input  logic [CNT_WIDTH-1:0]     frame_len,
  output logic                     busy,
  output logic                     done,
  output logic [CNT_WIDTH-1:0]     msg_count,
  output logic                     in_rd_en,
  input  logic [DATA_WIDTH-1:0]    in_rd_data,
  input  logic                     in_empty,
  input  logic                     in_rd_valid,
  output logic                     enc_valid,
  output logic [DATA_WIDTH-1:0]    enc_data,
  input  logic                     enc_ready,
  input  logic                     enc_out_valid,
  input  logic [HAMMING_WIDTH-1:0] enc_out_data,
  output logic                     out_wr_en,
  output logic [HAMMING_WIDTH-1:0] out_wr_data,
  input  logic                     out_full
);

  typedef enum logic [2:0] {
    IDLE, READ, WAIT_RD, ENCODE, WAIT_ENC, WRITE, DONE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(ENTRIES_BUFFER);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] len_q;
  logic [CNT_WIDTH-1:0] start_len;
  logic [CNT_WIDTH-1:0] count_inc;
  logic                 wr_fire;

  assign start_len = (frame_len > MAX_LEN) ? MAX_LEN : frame_len;
  assign count_inc = (msg_count == MAX_LEN) ? msg_count : msg_count + CNT_ONE;

  // Read and write strobes are suppressed in an abort cycle so that msg_count
  // always equals the number of words actually handed to the output buffer.
  assign wr_fire   = (state == WRITE) && !out_full && !abort;
  assign in_rd_en  = (state == READ) && !in_empty && !abort;
  assign out_wr_en = wr_fire;
  assign enc_valid = (state == ENCODE);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; abort overrides every other transition outside IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = (start_len == '0) ? DONE : READ;
      READ:     if (!in_empty) state_nxt = WAIT_RD;
      WAIT_RD:  if (in_rd_valid) state_nxt = ENCODE;
      ENCODE:   if (enc_ready) state_nxt = WAIT_ENC;
      WAIT_ENC: if (enc_out_valid) state_nxt = WRITE;
      WRITE:    if (!out_full) state_nxt = (count_inc == len_q) ? DONE : READ;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
  end

  // Frame length latch, message counter and the two data holding registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      msg_count   <= '0;
      enc_data    <= '0;
      out_wr_data <= '0;
    end else begin
      if (state == IDLE && start) begin
        len_q     <= start_len;
        msg_count <= '0;
      end
      if (state == WAIT_RD && in_rd_valid && !abort) enc_data <= in_rd_data;
      if (state == WAIT_ENC && enc_out_valid && !abort) out_wr_data <= enc_out_data;
      if (wr_fire) msg_count <= count_inc;
    end
  end

endmodule

// File: tb/tb_encoder_fec_ctrl.sv
// tb/tb_encoder_fec_ctrl.sv - scoreboard bench for encoder_fec_ctrl
module tb_encoder_fec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [10:0] frame_len;
  logic        busy, done;
  logic [10:0] msg_count;
  logic        in_rd_en;
  logic [7:0]  in_rd_data;
  logic        in_empty;
  logic        in_rd_valid;
  logic        enc_valid;
  logic [7:0]  enc_data;
  logic        enc_ready;
  logic        enc_out_valid;
  logic [15:0] enc_out_data;
  logic        out_wr_en;
  logic [15:0] out_wr_data;
  logic        out_full;

  always #5 clk = ~clk;

  encoder_fec_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_len(frame_len),
    .busy(busy), .done(done), .msg_count(msg_count),
    .in_rd_en(in_rd_en), .in_rd_data(in_rd_data), .in_empty(in_empty), .in_rd_valid(in_rd_valid),
    .enc_valid(enc_valid), .enc_data(enc_data), .enc_ready(enc_ready),
    .enc_out_valid(enc_out_valid), .enc_out_data(enc_out_data),
    .out_wr_en(out_wr_en), .out_wr_data(out_wr_data), .out_full(out_full)
  );

  // Reference Hamming(12,8) with overall parity, zero-padded to 16 bits
  function automatic logic [15:0] ham(input logic [7:0] d);
    logic [12:1] c;
    logic        p;
    c     = '0;
    c[3]  = d[0]; c[5]  = d[1]; c[6]  = d[2]; c[7]  = d[3];
    c[9]  = d[4]; c[10] = d[5]; c[11] = d[6]; c[12] = d[7];
    c[1]  = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
    c[2]  = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
    c[4]  = c[5] ^ c[6] ^ c[7] ^ c[12];
    c[8]  = c[9] ^ c[10] ^ c[11] ^ c[12];
    p     = ^c;
    return {3'b000, p, c};
  endfunction

  // Input buffer model: one-cycle read latency
  logic [7:0] mem [0:4095];
  int         rd_ptr = 0;
  int         wr_ptr = 0;
  logic       hold_empty;
  assign in_empty = hold_empty || (rd_ptr == wr_ptr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_rd_valid <= 1'b0;
      in_rd_data  <= '0;
    end else begin
      in_rd_valid <= in_rd_en;
      if (in_rd_en) begin
        in_rd_data <= mem[rd_ptr[11:0]];
        rd_ptr     <= rd_ptr + 1;
      end
    end
  end

  // Encoder model: result one cycle after acceptance; late_pulse injects a stray result
  logic late_pulse;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_out_valid <= 1'b0;
      enc_out_data  <= '0;
    end else begin
      enc_out_valid <= (enc_valid && enc_ready) || late_pulse;
      enc_out_data  <= ham(enc_data);
    end
  end

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_q[$];
  int          wr_cyc[$];
  int          cyc = 0;
  int          t0 = 0;
  int          wr_cnt, rd_cnt, done_cnt, bad_rd, bad_wr;
  int          done_cyc, idle_cyc;
  logic        prev_busy = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: sample on the falling edge, return 1 time unit after the rising edge
  task automatic cycle();
    @(negedge clk);
    if (out_wr_en) begin
      wr_cnt++;
      wr_cyc.push_back(cyc - t0);
      if (out_full) bad_wr++;
      if (exp_q.size() == 0) check("sb_extra_write", 32'(out_wr_data), 32'hFFFF_FFFF);
      else                   check("sb_word", 32'(out_wr_data), 32'(exp_q.pop_front()));
    end
    if (in_rd_en) begin
      rd_cnt++;
      if (hold_empty) bad_rd++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc - t0;
    end
    if (!busy && prev_busy && idle_cyc < 0) idle_cyc = cyc - t0;
    prev_busy = busy;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic push_msg(input logic [7:0] m);
    mem[wr_ptr[11:0]] = m;
    wr_ptr++;
    exp_q.push_back(ham(m));
  endtask

  task automatic clear_stats();
    wr_cnt = 0; rd_cnt = 0; done_cnt = 0; bad_rd = 0; bad_wr = 0;
    done_cyc = -1; idle_cyc = -1;
    wr_cyc.delete();
  endtask

  task automatic flush();
    exp_q.delete();
    wr_ptr = rd_ptr;
  endtask

  task automatic start_frame(input logic [10:0] len);
    frame_len = len;
    start     = 1'b1;
    t0        = cyc;
    cycle();
    start     = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while (busy && n < budget) begin
      cycle();
      n++;
    end
    if (busy) check({tag, "_timeout"}, 32'(busy), 32'd0);
    cycle();
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_len = '0;
    enc_ready = 1'b1; out_full = 1'b0; hold_empty = 1'b0; late_pulse = 1'b0;
    clear_stats();
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy",        32'(busy),        32'd0);
    check("rst_done",        32'(done),        32'd0);
    check("rst_in_rd_en",    32'(in_rd_en),    32'd0);
    check("rst_enc_valid",   32'(enc_valid),   32'd0);
    check("rst_out_wr_en",   32'(out_wr_en),   32'd0);
    check("rst_enc_data",    32'(enc_data),    32'd0);
    check("rst_out_wr_data", 32'(out_wr_data), 32'd0);
    check("rst_msg_count",   32'(msg_count),   32'd0);
    rst_n = 1'b1;
    cycle();

    // Back-to-back frame of four with exact cycle timing
    clear_stats();
    push_msg(8'h00); push_msg(8'h5A); push_msg(8'hFF); push_msg(8'h81);
    start_frame(11'd4);
    check("b2b_busy_cycle1", 32'(busy), 32'd1);
    wait_idle(200, "b2b");
    check("b2b_writes", 32'(wr_cnt), 32'd4);
    for (int i = 0; i < 4 && i < wr_cyc.size(); i++)
      check("b2b_write_cycle", 32'(wr_cyc[i]), 32'(5 * (i + 1)));
    check("b2b_done_cycle", 32'(done_cyc),  32'd21);
    check("b2b_idle_cycle", 32'(idle_cyc),  32'd22);
    check("b2b_done_count", 32'(done_cnt),  32'd1);
    check("b2b_msg_count",  32'(msg_count), 32'd4);

    // Stall boundaries: empty input, encoder back-pressure, full output
    clear_stats();
    hold_empty = 1'b1; enc_ready = 1'b0; out_full = 1'b1;
    push_msg(8'hC3);
    start_frame(11'd1);
    repeat (10) cycle();
    hold_empty = 1'b0;
    n = 0;
    while (!enc_valid && n < 20) begin cycle(); n++; end
    check("stall_enc_reached", 32'(enc_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("stall_enc_valid", 32'(enc_valid), 32'd1);
      check("stall_enc_data",  32'(enc_data),  32'h0C3);
      cycle();
    end
    check("stall_enc_data_hold", 32'(enc_data), 32'h0C3);
    enc_ready = 1'b1;
    n = 0;
    while (!enc_out_valid && n < 20) begin cycle(); n++; end
    cycle();
    for (int i = 0; i < 7; i++) begin
      check("stall_wr_en",   32'(out_wr_en),   32'd0);
      check("stall_wr_data", 32'(out_wr_data), 32'(ham(8'hC3)));
      cycle();
    end
    out_full = 1'b0;
    wait_idle(50, "stall");
    check("stall_rd_while_empty", 32'(bad_rd),    32'd0);
    check("stall_wr_while_full",  32'(bad_wr),    32'd0);
    check("stall_writes",         32'(wr_cnt),    32'd1);
    check("stall_msg_count",      32'(msg_count), 32'd1);

    // Zero-length frame
    clear_stats();
    start_frame(11'd0);
    wait_idle(10, "zero");
    check("zero_done_count", 32'(done_cnt), 32'd1);
    check("zero_done_cycle", 32'(done_cyc == 1 || done_cyc == 2), 32'd1);
    check("zero_reads",      32'(rd_cnt),    32'd0);
    check("zero_writes",     32'(wr_cnt),    32'd0);
    check("zero_msg_count",  32'(msg_count), 32'd0);

    // A start while busy must not restart or relatch the length
    clear_stats();
    push_msg(8'h12); push_msg(8'h34); push_msg(8'h56);
    start_frame(11'd3);
    repeat (4) cycle();
    frame_len = 11'd7; start = 1'b1;
    cycle();
    start = 1'b0;
    wait_idle(200, "ign");
    check("ign_writes",     32'(wr_cnt),    32'd3);
    check("ign_done_count", 32'(done_cnt),  32'd1);
    check("ign_msg_count",  32'(msg_count), 32'd3);

    // Abort during WRITE of the third message, then a stray encoder result
    clear_stats();
    for (int i = 0; i < 5; i++) push_msg(8'(8'h20 + i));
    start_frame(11'd5);
    n = 0;
    while (wr_cnt < 2 && n < 100) begin cycle(); n++; end
    n = 0;
    while (!enc_out_valid && n < 20) begin cycle(); n++; end
    check("abort_reached_wait_enc", 32'(enc_out_valid), 32'd1);
    cycle();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    check("abort_busy_next", 32'(busy), 32'd0);
    late_pulse = 1'b1;
    cycle();
    late_pulse = 1'b0;
    repeat (3) cycle();
    check("abort_busy_after_late", 32'(busy),      32'd0);
    check("abort_writes",          32'(wr_cnt),    32'd2);
    check("abort_no_done",         32'(done_cnt),  32'd0);
    check("abort_msg_count",       32'(msg_count), 32'd2);
    flush();

    // Asynchronous reset during WAIT_ENC of the second message
    clear_stats();
    push_msg(8'hA5); push_msg(8'h3C);
    start_frame(11'd2);
    n = 0;
    while (wr_cnt < 1 && n < 100) begin cycle(); n++; end
    n = 0;
    while (!enc_out_valid && n < 20) begin cycle(); n++; end
    rst_n = 1'b0;
    #1;
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_enc_valid", 32'(enc_valid), 32'd0);
    check("arst_out_wr_en", 32'(out_wr_en), 32'd0);
    check("arst_msg_count", 32'(msg_count), 32'd0);
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();
    flush();
    clear_stats();
    push_msg(8'h01); push_msg(8'h80); push_msg(8'h7E);
    start_frame(11'd3);
    wait_idle(200, "post_rst");
    check("post_rst_writes",    32'(wr_cnt),    32'd3);
    check("post_rst_done",      32'(done_cnt),  32'd1);
    check("post_rst_msg_count", 32'(msg_count), 32'd3);

    // Full-size frame with random output back-pressure
    clear_stats();
    for (int i = 0; i < 1024; i++) push_msg(8'($urandom));
    start_frame(11'd1024);
    n = 0;
    while (busy && n < 20000) begin
      out_full = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    out_full = 1'b0;
    if (busy) check("big_timeout", 32'(busy), 32'd0);
    cycle();
    check("big_writes",       32'(wr_cnt),       32'd1024);
    check("big_msg_count",    32'(msg_count),    32'd1024);
    check("big_done_count",   32'(done_cnt),     32'd1);
    check("big_wr_when_full", 32'(bad_wr),       32'd0);
    check("big_sb_leftover",  32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
